// File: rtl/axi4_stream_demux_pkg.sv
// Shared types for the packet demux: FSM state encoding and drop counter sizing.
package axi4_stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int DROP_CNT_W = 32;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle; 's' drives a stream out, 'd' receives one.
interface axi4_stream_if #(
  parameter int  DN = 1,
  parameter type DT = logic [8-1:0]
) ();

  logic           tvalid;
  logic           tready;
  DT [DN-1:0]     tdata;
  logic [DN-1:0]  tkeep;
  logic           tlast;

  modport s (output tvalid, tdata, tkeep, tlast, input tready);
  modport d (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/axi4_stream_reg.sv
// One-beat output register slice; load is only asserted when rdy is high.
module axi4_stream_reg #(
  parameter int  DN = 1,
  parameter type DT = logic [8-1:0]
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  DT [DN-1:0]     din,
  input  logic [DN-1:0]  kin,
  input  logic           lin,
  output logic           rdy,
  output logic           vld,
  output DT [DN-1:0]     dout,
  output logic [DN-1:0]  kout,
  output logic           lout,
  input  logic           oready
);

  // Accept when empty or when the held beat leaves this cycle.
  assign rdy = ~vld | oready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vld <= 1'b0;
    else if (load)   vld <= 1'b1;
    else if (oready) vld <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      kout <= '0;
      lout <= 1'b0;
    end else if (load) begin
      dout <= din;
      kout <= kin;
      lout <= lin;
    end
  end

endmodule

// File: rtl/axi4_stream_demux_pkt.sv
// Packet-granular AXI4-Stream demux: route chosen at the first beat, held to TLAST.
module axi4_stream_demux_pkt
  import axi4_stream_demux_pkg::*;
#(
  parameter int  SN = 2,
  parameter int  SW = (SN > 1) ? $clog2(SN) : 1,
  parameter int  DN = 1,
  parameter type DT = logic [8-1:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SW-1:0]          sel,
  axi4_stream_if.d               sti,
  axi4_stream_if.s               sto [SN-1:0],
  output logic                   busy,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  localparam int              SP   = 1 << SW;
  localparam logic [SW:0]     SN_L = (SW+1)'(SN);

  state_e          state;
  logic [SW-1:0]   sel_q;
  logic [SW-1:0]   cur_sel;
  logic            sel_ok;
  logic            hs;
  logic [SP-1:0]   rdy_pad;

  logic [SN-1:0]   load;
  logic [SN-1:0]   s_rdy;
  logic [SN-1:0]   s_vld;
  logic [SN-1:0]   s_last;
  logic [SN-1:0]   o_rdy;
  DT [DN-1:0]      s_data [SN];
  logic [DN-1:0]   s_keep [SN];

  // In IDLE the live sel decides; mid-packet only the latched route matters.
  always_comb begin
    cur_sel = (state == IDLE) ? sel : sel_q;
    sel_ok  = (state == IDLE) ? ({1'b0, sel} < SN_L) : (state == PASS);
    rdy_pad = '0;
    rdy_pad[SN-1:0] = s_rdy;
  end

  assign sti.tready = ~rst & (~sel_ok | rdy_pad[cur_sel]);
  assign hs         = sti.tvalid & sti.tready;

  for (genvar g = 0; g < SN; g++) begin : g_out
    assign load[g] = hs & sel_ok & (cur_sel == SW'(g));

    axi4_stream_reg #(.DN(DN), .DT(DT)) u_slice (
      .clk    (clk),
      .rst    (rst),
      .load   (load[g]),
      .din    (sti.tdata),
      .kin    (sti.tkeep),
      .lin    (sti.tlast),
      .rdy    (s_rdy[g]),
      .vld    (s_vld[g]),
      .dout   (s_data[g]),
      .kout   (s_keep[g]),
      .lout   (s_last[g]),
      .oready (o_rdy[g])
    );

    assign sto[g].tvalid = s_vld[g];
    assign sto[g].tdata  = s_data[g];
    assign sto[g].tkeep  = s_keep[g];
    assign sto[g].tlast  = s_last[g];
    assign o_rdy[g]      = sto[g].tready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      busy     <= 1'b0;
      drop_cnt <= '0;
    end else if (hs) begin
      if (state == IDLE) sel_q <= sel;
      if (sti.tlast) begin
        // Covers single-beat packets too: they never leave IDLE.
        state <= IDLE;
        busy  <= 1'b0;
        if (!sel_ok) drop_cnt <= sat_inc(drop_cnt);
      end else if (state == IDLE) begin
        state <= sel_ok ? PASS : DROP;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_stream_demux_pkt.sv
// Directed bench: SN=4 instance for routing/backpressure/reset, SN=3 instance for drops.
module tb_axi4_stream_demux_pkt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0]  sel_a, sel_b;
  logic        busy_a, busy_b;
  logic [31:0] drop_a, drop_b;

  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sti_a ();
  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sti_b ();
  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sto_a [3:0] ();
  axi4_stream_if #(.DN(1), .DT(logic [7:0])) sto_b [2:0] ();

  axi4_stream_demux_pkt #(.SN(4), .SW(2), .DN(1), .DT(logic [7:0])) u_a (
    .clk(clk), .rst(rst), .sel(sel_a), .sti(sti_a), .sto(sto_a),
    .busy(busy_a), .drop_cnt(drop_a)
  );

  axi4_stream_demux_pkt #(.SN(3), .SW(2), .DN(1), .DT(logic [7:0])) u_b (
    .clk(clk), .rst(rst), .sel(sel_b), .sti(sti_b), .sto(sto_b),
    .busy(busy_b), .drop_cnt(drop_b)
  );

  logic [3:0] va, la, ra;
  logic [7:0] da [4];
  logic [2:0] vb;

  for (genvar g = 0; g < 4; g++) begin : g_a
    assign va[g] = sto_a[g].tvalid;
    assign la[g] = sto_a[g].tlast;
    assign da[g] = sto_a[g].tdata[0];
    assign sto_a[g].tready = ra[g];
  end
  for (genvar g = 0; g < 3; g++) begin : g_b
    assign vb[g] = sto_b[g].tvalid;
    assign sto_b[g].tready = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ra = 4'hF;
    sel_a = '0; sti_a.tvalid = 0; sti_a.tdata = '0; sti_a.tkeep = 1'b1; sti_a.tlast = 0;
    sel_b = '0; sti_b.tvalid = 0; sti_b.tdata = '0; sti_b.tkeep = 1'b1; sti_b.tlast = 0;

    // reset state
    @(negedge clk);
    chk("rst_vld", {28'd0, va}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_drop", drop_a, 32'd0);
    chk("rst_tready", {31'd0, sti_a.tready}, 32'd0);
    tick();
    rst = 0;

    // 3-beat packet to 2, sel moves to 1 mid-packet
    sel_a = 2; sti_a.tvalid = 1; sti_a.tdata = 8'hA1; sti_a.tlast = 0;
    @(negedge clk); chk("r30_rdy", {31'd0, sti_a.tready}, 32'd1);
    tick();
    sel_a = 1; sti_a.tdata = 8'hA2;
    @(negedge clk);
    chk("r30_v1", {28'd0, va}, 32'h4); chk("r30_d1", {24'd0, da[2]}, 32'hA1);
    chk("r30_busy", {31'd0, busy_a}, 32'd1);
    tick();
    sti_a.tdata = 8'hA3; sti_a.tlast = 1;
    @(negedge clk);
    chk("r30_v2", {28'd0, va}, 32'h4); chk("r30_d2", {24'd0, da[2]}, 32'hA2);
    chk("r30_l2", {31'd0, la[2]}, 32'd0);
    tick();
    sti_a.tvalid = 0; sti_a.tlast = 0;
    @(negedge clk);
    chk("r30_v3", {28'd0, va}, 32'h4); chk("r30_d3", {24'd0, da[2]}, 32'hA3);
    chk("r30_l3", {31'd0, la[2]}, 32'd1); chk("r30_idle", {31'd0, busy_a}, 32'd0);
    tick();
    @(negedge clk); chk("r30_drain", {28'd0, va}, 32'd0);

    // backpressure on output 0 for 4 cycles
    tick();
    sel_a = 0; sti_a.tvalid = 1; sti_a.tdata = 8'hB0; sti_a.tlast = 0;
    @(negedge clk); chk("r32_rdy0", {31'd0, sti_a.tready}, 32'd1);
    tick();
    sti_a.tdata = 8'hB1; ra[0] = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("r32_stall_rdy", {31'd0, sti_a.tready}, 32'd0);
      chk("r32_hold_d", {24'd0, da[0]}, 32'hB0);
      chk("r32_hold_v", {31'd0, va[0]}, 32'd1);
      tick();
    end
    ra[0] = 1;
    @(negedge clk);
    chk("r32_resume_rdy", {31'd0, sti_a.tready}, 32'd1); chk("r32_o0", {24'd0, da[0]}, 32'hB0);
    tick();
    sti_a.tdata = 8'hB2;
    @(negedge clk); chk("r32_o1", {24'd0, da[0]}, 32'hB1);
    tick();
    sti_a.tdata = 8'hB3; sti_a.tlast = 1;
    @(negedge clk); chk("r32_o2", {24'd0, da[0]}, 32'hB2);
    tick();
    sti_a.tvalid = 0; sti_a.tlast = 0;
    @(negedge clk);
    chk("r32_o3", {24'd0, da[0]}, 32'hB3); chk("r32_l3", {31'd0, la[0]}, 32'd1);
    tick();
    @(negedge clk); chk("r32_empty", {28'd0, va}, 32'd0);

    // back-to-back single-beat packets 0,1,0,1
    tick();
    sti_a.tvalid = 1; sti_a.tlast = 1; sel_a = 0; sti_a.tdata = 8'hC0;
    tick();
    sel_a = 1; sti_a.tdata = 8'hC1;
    @(negedge clk);
    chk("r33_v0", {28'd0, va}, 32'h1); chk("r33_d0", {24'd0, da[0]}, 32'hC0);
    chk("r33_busy0", {31'd0, busy_a}, 32'd0);
    tick();
    sel_a = 0; sti_a.tdata = 8'hC2;
    @(negedge clk);
    chk("r33_v1", {28'd0, va}, 32'h2); chk("r33_d1", {24'd0, da[1]}, 32'hC1);
    tick();
    sel_a = 1; sti_a.tdata = 8'hC3;
    @(negedge clk);
    chk("r33_v2", {28'd0, va}, 32'h1); chk("r33_d2", {24'd0, da[0]}, 32'hC2);
    tick();
    sti_a.tvalid = 0; sti_a.tlast = 0;
    @(negedge clk);
    chk("r33_v3", {28'd0, va}, 32'h2); chk("r33_d3", {24'd0, da[1]}, 32'hC3);
    chk("r33_busy3", {31'd0, busy_a}, 32'd0);
    tick();

    // reset pulse during beat 2 of a 4-beat packet
    sel_a = 0; sti_a.tvalid = 1; sti_a.tdata = 8'hD0; sti_a.tlast = 0;
    tick();
    sti_a.tdata = 8'hD1;
    @(negedge clk); chk("r34_pre", {28'd0, va}, 32'h1);
    #2 rst = 1;
    #1;
    chk("r34_vld", {28'd0, va}, 32'd0);
    chk("r34_busy", {31'd0, busy_a}, 32'd0);
    chk("r34_rdy", {31'd0, sti_a.tready}, 32'd0);
    tick();
    rst = 0; sti_a.tvalid = 0;
    tick();
    sel_a = 1; sti_a.tvalid = 1; sti_a.tdata = 8'hE0;
    @(negedge clk); chk("r34_rdy_post", {31'd0, sti_a.tready}, 32'd1);
    tick();
    sti_a.tdata = 8'hE1; sti_a.tlast = 1;
    @(negedge clk);
    chk("r34_v0", {28'd0, va}, 32'h2); chk("r34_d0", {24'd0, da[1]}, 32'hE0);
    tick();
    sti_a.tvalid = 0; sti_a.tlast = 0;
    @(negedge clk);
    chk("r34_v1", {28'd0, va}, 32'h2); chk("r34_d1", {24'd0, da[1]}, 32'hE1);
    chk("r34_l1", {31'd0, la[1]}, 32'd1);
    tick();

    // SN=3: sel=3 drops a 5-beat packet
    sel_b = 3; sti_b.tvalid = 1;
    for (int i = 0; i < 5; i++) begin
      sti_b.tdata = 8'(8'hF0 + i); sti_b.tlast = (i == 4);
      @(negedge clk);
      chk("r31_rdy", {31'd0, sti_b.tready}, 32'd1);
      chk("r31_novld", {29'd0, vb}, 32'd0);
      chk("r31_cnt0", drop_b, 32'd0);
      tick();
    end
    sti_b.tvalid = 0; sti_b.tlast = 0;
    @(negedge clk);
    chk("r31_cnt1", drop_b, 32'd1);
    chk("r31_novld_end", {29'd0, vb}, 32'd0);
    chk("r31_idle", {31'd0, busy_b}, 32'd0);

    // saturation: preload counter, then two more drops
    force u_b.drop_cnt = 32'hFFFF_FFFE;
    #1;
    release u_b.drop_cnt;
    @(negedge clk); chk("r35_pre", drop_b, 32'hFFFF_FFFE);
    tick();
    sti_b.tvalid = 1; sti_b.tlast = 1; sel_b = 3; sti_b.tdata = 8'h11;
    tick();
    sti_b.tvalid = 0; sti_b.tlast = 0;
    @(negedge clk); chk("r35_max", drop_b, 32'hFFFF_FFFF);
    tick();
    sti_b.tvalid = 1; sti_b.tlast = 1; sti_b.tdata = 8'h22;
    tick();
    sti_b.tvalid = 0; sti_b.tlast = 0;
    @(negedge clk); chk("r35_sat", drop_b, 32'hFFFF_FFFF);
    chk("r35_novld", {29'd0, vb}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
